bias_update: RTL
================

Name: bias_update

Overview:
- Consumer end of the delta stream that the delta stage broadcasts.
- Accepts one NC-lane signed delta vector per sample and accumulates each lane over a mini-batch of BATCH samples.
- At batch end, applies bias_new = sat(bias - (sum >>> LR_SHIFT)) per lane and presents the updated bias vector downstream on a valid/ready channel.
- Sits beside the weight-update path of each layer and feeds the bias input of the forward neuron.

Parameters:
- NC, 6, number of lanes (neurons in the current layer).
- WF, 4, width of one signed delta/bias lane (two's complement, WF-1 fraction bits).
- BATCH, 4, samples per update; must be >= 1.
- LR_SHIFT, 2, learning rate as an arithmetic right shift of the batch sum; 0..WF+clog2(BATCH).

Ports:
- iCLK  input  1  clock
- iRST  input  1  reset, synchronous, active-low
- iValid_AM_Delta  input  1  delta vector valid
- oReady_AM_Delta  output  1  delta vector ready
- iData_AM_Delta  input  NC*WF  delta lanes; lane i at [i*WF+:WF]
- oValid_BM_Bias  output  1  updated bias valid
- iReady_BM_Bias  input  1  downstream ready
- oData_BM_Bias  output  NC*WF  bias lanes; lane i at [i*WF+:WF]

Behaviour:
- Reset is sampled on the iCLK rising edge while iRST==0. It applies mid-batch or mid-emit without exception.
- Reset values: state=ACCUM, count=0, all accumulators=0, all bias registers=0, oValid_BM_Bias=0, oData_BM_Bias=0. oReady_AM_Delta=0 while iRST==0.
- Widths:
  - Accumulator WS = WF + clog2(BATCH), signed.
  - Delta is sign-extended to WS before adding.
  - Update math is done at WS+1 bits so overflow is impossible.
  - Saturation bounds: MAX = 2^(WF-1)-1, MIN = -2^(WF-1).
- States: ACCUM, EMIT.
  - ACCUM: oReady_AM_Delta=1, oValid_BM_Bias=0.
  - On a delta handshake (iValid && oReady):
    - If count < BATCH-1: acc_i += delta_i and count++.
    - If count == BATCH-1: compute s_i = acc_i + delta_i, register bias_i = sat(bias_i - (s_i >>> LR_SHIFT)), clear acc_i and count, go to EMIT.
  - EMIT: oValid_BM_Bias=1, oReady_AM_Delta=0, no burst/overlap. oData_BM_Bias holds the bias registers and stays stable until the handshake.
  - On iReady_BM_Bias==1 in EMIT: return to ACCUM next cycle.
- Latency: last delta handshake at cycle t gives oValid_BM_Bias=1 at t+1. Minimum period is BATCH+1 cycles per update.
- oData_BM_Bias always reflects the current bias registers, including outside EMIT.
- Shift is arithmetic (floor) unless BIAS_UPDATE_ROUND_EN is defined.
- BATCH==1: every accepted delta goes straight to EMIT.
- iValid low in ACCUM: nothing changes; count is retained indefinitely.
- Downstream backpressure in EMIT: deltas are refused; upstream stalls.

Optional Feature:
- Macro BIAS_UPDATE_ROUND_EN.
- Defined: when LR_SHIFT>0, add 2^(LR_SHIFT-1) to s_i before the shift (round half up). Examples: 3>>>1 gives 2, -3>>>1 gives -1.
- Undefined: plain arithmetic shift (floor). Examples: 3>>>1 gives 1, -3>>>1 gives -2.
- LR_SHIFT==0: identical either way.

Decomposition:
- Package bias_update_pkg holds:
  - state typedef {ACCUM, EMIT};
  - width function for WS;
  - constant functions for saturation MAX/MIN given WF.
- One sub-module, bias_update_lane, instantiated NC times. It contains the per-lane accumulator, the update arithmetic and saturation, and the bias register. It has enable/clear inputs driven by the shared FSM and counter in bias_update.

Test Plan:
- Parameters NC=2, WF=4, BATCH=4, LR_SHIFT=1, macro undefined. Four deltas {lane1=-3, lane0=2}, iReady=1 → oValid one cycle after the 4th handshake, bias {6, -4}, oReady low exactly that cycle.
- Continue with four deltas {0, 7} → lane0 = -4 - 14 = -18 saturates to -8; lane1 stays 6.
- Hold iReady_BM_Bias=0 for 5 cycles in EMIT with iValid=1 → oValid stays 1, oData stable, oReady=0, no delta consumed. iReady=1 → one handshake, then ACCUM.
- After two deltas of {1, 1}, pulse iRST=0 for one cycle, then four deltas of {1, 1} → bias {-2, -2}; the pre-reset deltas have no effect.
- BATCH=1, LR_SHIFT=1, lane0 delta 3 → undefined macro gives bias -1; BIAS_UPDATE_ROUND_EN defined gives -2. Lane0 delta -3 → undefined gives 2; defined gives 1.
- Random iValid/iReady gaps over 100 batches → bias matches a reference model; no lost or duplicated delta; outputs stable under backpressure.

Source files
------------

// File: rtl/bias_update_pkg.sv
// Shared types and width helpers for the bias_update block.
// Width helpers are constant functions so they can size parameters.
package bias_update_pkg;

  typedef enum logic {ACCUM, EMIT} state_t;

  function automatic int ws_width(input int wf, input int batch);
    return wf + $clog2(batch);
  endfunction

  function automatic int sat_max(input int wf);
    return (1 << (wf - 1)) - 1;
  endfunction

  function automatic int sat_min(input int wf);
    return -(1 << (wf - 1));
  endfunction

endpackage

// File: rtl/bias_update_lane.sv
// One lane of the bias updater: batch accumulator, shift/saturate update and bias register.
// BIAS_UPDATE_ROUND_EN selects round-half-up instead of floor for the learning-rate shift.
module bias_update_lane
  import bias_update_pkg::*;
#(
  parameter int WF       = 4,
  parameter int BATCH    = 4,
  parameter int LR_SHIFT = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_acc_en,
  input  logic          i_update,
  input  logic [WF-1:0] i_delta,
  output logic [WF-1:0] o_bias
);

  localparam int WS = ws_width(WF, BATCH);
  localparam logic signed [WS:0] SAT_MAX = (WS+1)'(sat_max(WF));
  localparam logic signed [WS:0] SAT_MIN = (WS+1)'(sat_min(WF));
`ifdef BIAS_UPDATE_ROUND_EN
  localparam logic signed [WS:0] RND = (WS+1)'((1 << LR_SHIFT) >> 1);
`else
  localparam logic signed [WS:0] RND = '0;
`endif

  logic signed [WS-1:0] r_acc;
  logic signed [WF-1:0] r_bias;
  logic signed [WS:0]   w_sum;
  logic signed [WS:0]   w_shifted;
  logic signed [WS:0]   w_diff;
  logic signed [WF-1:0] w_bias_next;

  // One extra bit keeps both the rounding add and the subtraction overflow-free.
  always_comb begin
    w_sum     = $signed({r_acc[WS-1], r_acc}) + $signed({{(WS+1-WF){i_delta[WF-1]}}, i_delta});
    w_shifted = (w_sum + RND) >>> LR_SHIFT;
    w_diff    = $signed({{(WS+1-WF){r_bias[WF-1]}}, r_bias}) - w_shifted;
    if (w_diff > SAT_MAX) begin
      w_bias_next = SAT_MAX[WF-1:0];
    end else if (w_diff < SAT_MIN) begin
      w_bias_next = SAT_MIN[WF-1:0];
    end else begin
      w_bias_next = w_diff[WF-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc  <= '0;
      r_bias <= '0;
    end else if (i_update) begin
      r_acc  <= '0;
      r_bias <= w_bias_next;
    end else if (i_acc_en) begin
      r_acc  <= w_sum[WS-1:0];
    end
  end

  assign o_bias = r_bias;

endmodule

// File: rtl/bias_update.sv
// Mini-batch bias updater: accumulates BATCH delta vectors, then emits sat(bias - (sum >>> LR_SHIFT)).
// Optional macro BIAS_UPDATE_ROUND_EN enables round-half-up on the shift (see bias_update_lane).
module bias_update
  import bias_update_pkg::*;
#(
  parameter int NC       = 6,
  parameter int WF       = 4,
  parameter int BATCH    = 4,
  parameter int LR_SHIFT = 2
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iValid_AM_Delta,
  output logic             oReady_AM_Delta,
  input  logic [NC*WF-1:0] iData_AM_Delta,
  output logic             oValid_BM_Bias,
  input  logic             iReady_BM_Bias,
  output logic [NC*WF-1:0] oData_BM_Bias
);

  localparam int CW = (BATCH > 1) ? $clog2(BATCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(BATCH - 1);

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic          r_valid;
  logic          w_hs;
  logic          w_last;
  logic          w_acc_en;
  logic          w_update;

  // Ready is forced low combinationally while reset is held.
  assign oReady_AM_Delta = iRST && (r_state == ACCUM);
  assign oValid_BM_Bias  = r_valid;
  assign w_hs            = iValid_AM_Delta && oReady_AM_Delta;
  assign w_last          = (r_count == LAST);
  assign w_acc_en        = w_hs && !w_last;
  assign w_update        = w_hs && w_last;

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      r_state <= ACCUM;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_hs) begin
            if (w_last) begin
              r_count <= '0;
              r_state <= EMIT;
              r_valid <= 1'b1;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        EMIT: begin
          if (iReady_BM_Bias) begin
            r_state <= ACCUM;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ACCUM;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NC; g++) begin : g_lane
    bias_update_lane #(
      .WF      (WF),
      .BATCH   (BATCH),
      .LR_SHIFT(LR_SHIFT)
    ) u_lane (
      .i_clk   (iCLK),
      .i_rst_n (iRST),
      .i_acc_en(w_acc_en),
      .i_update(w_update),
      .i_delta (iData_AM_Delta[g*WF +: WF]),
      .o_bias  (oData_BM_Bias[g*WF +: WF])
    );
  end

endmodule
